// File: rtl/frame_buffer_writer_pkg.sv
// rtl/frame_buffer_writer_pkg.sv - shared state type and frame geometry defaults for the camera frame buffer
package cam_fb_pkg;

  localparam int unsigned H_RES_DEF      = 1280;
  localparam int unsigned V_RES_DEF      = 720;
  localparam int unsigned ADDR_WIDTH_DEF = 20;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    FLUSH  = 2'd2
  } fbw_state_e;

  // One extra bit so a counter can reach the limit and be seen as clipped.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/frame_buffer_writer_if.sv
// rtl/frame_buffer_writer_if.sv - camera pixel input and RAM write port bundle
interface frame_buffer_writer_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 20
);
  logic [DATA_WIDTH-1:0] vin_data;
  logic                  vin_de;
  logic                  vin_vs;
  logic                  vin_hs;
  logic [ADDR_WIDTH-1:0] ram_wr_addr;
  logic [DATA_WIDTH-1:0] ram_wr_data;
  logic                  ram_wr_en;
  logic                  ram_wr_ready;

  modport master (
    input  vin_data, vin_de, vin_vs, vin_hs,
    output ram_wr_addr, ram_wr_data, ram_wr_en,
    input  ram_wr_ready
  );

  modport slave (
    output vin_data, vin_de, vin_vs, vin_hs,
    input  ram_wr_addr, ram_wr_data, ram_wr_en,
    output ram_wr_ready
  );
endinterface

// File: rtl/frame_buffer_writer_sync_fifo.sv
// rtl/frame_buffer_writer_sync_fifo.sv - show-ahead synchronous FIFO, push accepted when full if a pop frees a slot
module sync_fifo #(
  parameter int unsigned WIDTH = 36,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             do_push;
  logic             do_pop;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end
endmodule

// File: rtl/frame_buffer_writer.sv
// rtl/frame_buffer_writer.sv - turns the raw camera stream into linear-address RAM writes
// with frame completion and sticky loss/clip status.
module frame_buffer_writer
  import cam_fb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned H_RES      = H_RES_DEF,
  parameter int unsigned V_RES      = V_RES_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter bit          VS_POL     = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic                         clr_status,
  frame_buffer_writer_if.master        vif,
  output logic                         frame_done,
  output logic                         busy,
  output logic                         overflow,
  output logic                         clip_err,
  output logic [9:0]                   line_cnt
);
  localparam int unsigned X_W = cnt_width(H_RES);
  localparam int unsigned Y_W = cnt_width(V_RES);
  localparam int unsigned E_W = ADDR_WIDTH + DATA_WIDTH;
  localparam logic [X_W-1:0]        X_LIM     = X_W'(H_RES);
  localparam logic [Y_W-1:0]        Y_LIM     = Y_W'(V_RES);
  localparam logic [ADDR_WIDTH-1:0] LINE_STEP = ADDR_WIDTH'(H_RES);

  logic                  de_q, de_d, de_prev_q, de_prev_d;
  logic                  vs_q, vs_d, vs_prev_q, vs_prev_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [X_W-1:0]        x_q, x_d;
  logic [Y_W-1:0]        y_q, y_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [9:0]            line_cnt_q, line_cnt_d;
  fbw_state_e            state_q, state_d;
  logic                  frame_done_q, frame_done_d;
  logic                  overflow_q, overflow_d;
  logic                  clip_err_q, clip_err_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;

  logic                  vs_start, de_fall, count_en, clipped;
  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic                  out_load, ovf_set, clip_set;
  logic [ADDR_WIDTH-1:0] pix_addr;
  logic [E_W-1:0]        fifo_head;
  logic                  unused_hs;

  // Horizontal sync carries no information the de edges do not already give.
  assign unused_hs = vif.vin_hs;

  always_comb begin
    de_d      = vif.vin_de;
    vs_d      = (vif.vin_vs == VS_POL);
    data_d    = vif.vin_data;
    de_prev_d = de_q;
    vs_prev_d = vs_q;
  end

  assign vs_start = vs_q && !vs_prev_q;
  assign de_fall  = de_prev_q && !de_q;
  assign count_en = (state_q != FLUSH);
  assign clipped  = (x_q >= X_LIM) || (y_q >= Y_LIM);
  assign pix_addr = base_q + ADDR_WIDTH'(x_q);

  // base tracks y*H_RES incrementally so no multiplier is needed.
  always_comb begin
    x_d        = x_q;
    y_d        = y_q;
    base_d     = base_q;
    line_cnt_d = line_cnt_q;
    if (vs_start) begin
      x_d        = '0;
      y_d        = '0;
      base_d     = '0;
      line_cnt_d = '0;
    end else if (count_en && de_fall) begin
      x_d = '0;
      if (y_q != '1) begin
        y_d    = y_q + Y_W'(1);
        base_d = base_q + LINE_STEP;
      end
      if (line_cnt_q != '1) line_cnt_d = line_cnt_q + 10'd1;
    end else if (count_en && de_q) begin
      if (x_q != '1) x_d = x_q + X_W'(1);
    end
  end

  always_comb begin
    state_d      = state_q;
    frame_done_d = 1'b0;
    case (state_q)
      IDLE:   if (vs_start && enable) state_d = ACTIVE;
      ACTIVE: if (vs_start) state_d = FLUSH;
      FLUSH: begin
        if (fifo_empty && !wr_en_q) begin
          frame_done_d = 1'b1;
          state_d      = enable ? ACTIVE : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign fifo_push = (state_q == ACTIVE) && de_q && !clipped;
  assign clip_set  = (state_q == ACTIVE) && de_q && clipped;
  assign ovf_set   = fifo_push && fifo_full && !fifo_pop;

  always_comb begin
    overflow_d = ovf_set  || (overflow_q && !clr_status);
    clip_err_d = clip_set || (clip_err_q && !clr_status);
  end

  // The output register only refills when empty or when its word is taken.
  assign out_load = !wr_en_q || vif.ram_wr_ready;
  assign fifo_pop = out_load && !fifo_empty;

  always_comb begin
    wr_en_d   = wr_en_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (out_load) begin
      wr_en_d = !fifo_empty;
      if (!fifo_empty) begin
        wr_addr_d = fifo_head[E_W-1:DATA_WIDTH];
        wr_data_d = fifo_head[DATA_WIDTH-1:0];
      end
    end
  end

  sync_fifo #(
    .WIDTH (E_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data ({pix_addr, data_q}),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_q         <= 1'b0;
      de_prev_q    <= 1'b0;
      vs_q         <= 1'b0;
      vs_prev_q    <= 1'b0;
      data_q       <= '0;
      x_q          <= '0;
      y_q          <= '0;
      base_q       <= '0;
      line_cnt_q   <= '0;
      state_q      <= IDLE;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      clip_err_q   <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      de_q         <= de_d;
      de_prev_q    <= de_prev_d;
      vs_q         <= vs_d;
      vs_prev_q    <= vs_prev_d;
      data_q       <= data_d;
      x_q          <= x_d;
      y_q          <= y_d;
      base_q       <= base_d;
      line_cnt_q   <= line_cnt_d;
      state_q      <= state_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
      clip_err_q   <= clip_err_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
    end
  end

  assign vif.ram_wr_en   = wr_en_q;
  assign vif.ram_wr_addr = wr_addr_q;
  assign vif.ram_wr_data = wr_data_q;
  assign frame_done      = frame_done_q;
  assign busy            = (state_q != IDLE);
  assign overflow        = overflow_q;
  assign clip_err        = clip_err_q;
  assign line_cnt        = line_cnt_q;
endmodule
